// File: rtl/venc1_rm_if.sv
// Handshake bundle between the rate-matching puncturer and its producer/consumer.
// The master side drives block control, coded input bits and output backpressure.
interface venc1_rm_if;
  logic       start;
  logic [1:0] hs_mode;
  logic       in_vld;
  logic       in_bit;
  logic       in_rdy;
  logic       out_vld;
  logic       out_bit;
  logic       out_last;
  logic       out_rdy;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, hs_mode, in_vld, in_bit, out_rdy,
    input  in_rdy, out_vld, out_bit, out_last, busy, done, err
  );

  modport slave (
    input  start, hs_mode, in_vld, in_bit, out_rdy,
    output in_rdy, out_vld, out_bit, out_last, busy, done, err
  );
endinterface

// File: rtl/venc1_rm.sv
// Transmit-side rate matching for HS-SCCH part1/part2 and AGCH: drops fixed
// puncture positions from the rate-1/3 coded stream and emits the kept bits.
module venc1_rm #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned CNT_W = 7
) (
  input logic       clk,
  input logic       rst,
  venc1_rm_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [1:0]       mode_reg;
  logic [IDX_W-1:0] idx, idx_last;
  logic [CNT_W-1:0] ocnt, ocnt_last;
  logic [31:0]      idx_w;
  logic             out_vld_q, out_bit_q, out_last_q, done_q, err_q;
  logic             in_rdy, punct, accept, keep, launch, drained;

  assign bus.in_rdy   = in_rdy;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_bit  = out_bit_q;
  assign bus.out_last = out_last_q;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.err      = err_q;

  assign accept = in_rdy & bus.in_vld;
  assign keep   = accept & ~punct;
  assign idx_w  = 32'(idx);

  always_comb begin
    idx_last  = IDX_W'(47);
    ocnt_last = CNT_W'(39);
    case (mode_reg)
      2'b01: begin idx_last = IDX_W'(110); ocnt_last = CNT_W'(79); end
      2'b10: begin idx_last = IDX_W'(89);  ocnt_last = CNT_W'(59); end
      default: ;
    endcase
  end

  always_comb begin
    punct = 1'b0;
    case (mode_reg)
      2'b00: punct = idx_w inside {0, 1, 3, 7, 41, 44, 46, 47};
      2'b01: punct = idx_w inside {[0:7], 11, 13, 14, 23, 41, 47, 53, 56, 59, 65, 68,
                                   95, 98, 100, 101, [103:110]};
      2'b10: punct = idx_w inside {0, 1, 4, 5, 6, 10, 11, 13, 14, 16, 22, 23, 30, 36, 43,
                                   46, 60, 62, 63, 70, 71, 74, 76, 79, [82:84], 86, 87, 89};
      default: punct = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    launch    = 1'b0;
    drained   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && bus.hs_mode != 2'b11) begin
          launch    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        in_rdy = ~out_vld_q | bus.out_rdy;
        if (in_rdy && bus.in_vld && idx == idx_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Done may fire in the same cycle the last held bit is taken.
        if (!out_vld_q || bus.out_rdy) begin
          drained   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg   <= '0;
      idx        <= '0;
      ocnt       <= '0;
      out_vld_q  <= 1'b0;
      out_bit_q  <= 1'b0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= drained;
      err_q  <= (state == IDLE) && bus.start && (bus.hs_mode == 2'b11);
      if (launch) begin
        mode_reg <= bus.hs_mode;
        idx      <= '0;
        ocnt     <= '0;
      end else begin
        if (accept && idx != idx_last) idx  <= idx + 1'b1;
        if (keep && ocnt != ocnt_last) ocnt <= ocnt + 1'b1;
      end
      if (out_vld_q && bus.out_rdy) begin
        out_vld_q  <= 1'b0;
        out_last_q <= 1'b0;
      end
      if (keep) begin
        out_vld_q  <= 1'b1;
        out_bit_q  <= bus.in_bit;
        out_last_q <= (ocnt == ocnt_last);
      end
    end
  end

endmodule
